// File: rtl/disp_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : disp_pattern_gen
// Description : Hex-display test pattern generator. Produces NDIG nibbles
//               (overlapping binary, BCD count, digit rotate, uniform) plus a
//               rotating one-hot decimal point, advanced either by an internal
//               prescaler (run=1) or by single-step pulses (run=0).
// Revision    : 1.0 - initial release
// ============================================================================
module disp_pattern_gen #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 4194304
) (
  input  logic              clk5,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              run,
  input  logic              step,
  input  logic              clr,
  input  logic              pointEn,
  output logic [4*NDIG-1:0] dispVal,
  output logic [NDIG-1:0]   point,
  output logic              tick
);

  localparam int             c_CW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(PRESCALE - 1);
  localparam logic [NDIG-1:0] c_PTR_INIT = NDIG'(1);

  // Power-on / re-entry pattern for a given mode: digit i = i for rotate,
  // all zeros for the other three modes.
  function automatic logic [4*NDIG-1:0] init_pattern(input logic [1:0] m);
    logic [4*NDIG-1:0] p;
    p = '0;
    for (int i = 0; i < NDIG; i++) begin
      p[4*i +: 4] = (m == 2'd2) ? 4'(i) : 4'h0;
    end
    return p;
  endfunction

  logic [c_CW-1:0]   r_cnt;
  logic [NDIG+2:0]   r_c;
  logic [4*NDIG-1:0] r_disp;
  logic [NDIG-1:0]   r_ptr;
  logic [NDIG-1:0]   r_point;
  logic              r_tick;
  logic [1:0]        r_last_mode;

  logic              w_reinit;
  logic              w_adv;
  logic [NDIG+2:0]   w_c_next;
  logic [NDIG-1:0]   w_ptr_next;
  logic [4*NDIG-1:0] w_disp_next;
  logic              w_carry;
  logic [3:0]        w_nib;

  // A mode change and clr both restart the pattern; step only counts when frozen.
  assign w_reinit   = clr || (mode != r_last_mode);
  assign w_adv      = run ? (r_cnt == c_CNT_MAX) : step;
  assign w_c_next   = r_c + 1'b1;
  assign w_ptr_next = {r_ptr[NDIG-2:0], r_ptr[NDIG-1]};
  assign w_nib      = r_disp[3:0] + 4'd1;

  // Next displayed value should the current cycle advance.
  always_comb begin
    w_disp_next = r_disp;
    w_carry     = 1'b1;
    case (r_last_mode)
      2'd0: begin
        for (int i = 0; i < NDIG; i++) begin
          w_disp_next[4*i +: 4] = w_c_next[i +: 4];
        end
      end
      2'd1: begin
        for (int i = 0; i < NDIG; i++) begin
          if (w_carry) begin
            if (r_disp[4*i +: 4] == 4'd9) begin
              w_disp_next[4*i +: 4] = 4'd0;
            end else begin
              w_disp_next[4*i +: 4] = r_disp[4*i +: 4] + 4'd1;
              w_carry               = 1'b0;
            end
          end
        end
      end
      2'd2: w_disp_next = {r_disp[4*NDIG-5:0], r_disp[4*NDIG-1 -: 4]};
      default: w_disp_next = {NDIG{w_nib}};
    endcase
  end

  // Prescaler, pattern state, pointer and registered outputs.
  always_ff @(posedge clk5) begin
    if (reset || w_reinit) begin
      r_cnt       <= '0;
      r_c         <= '0;
      r_disp      <= init_pattern(mode);
      r_ptr       <= c_PTR_INIT;
      r_point     <= pointEn ? c_PTR_INIT : '0;
      r_tick      <= 1'b0;
      r_last_mode <= mode;
    end else begin
      if (run) begin
        r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_adv) begin
        if (r_last_mode == 2'd0) begin
          r_c <= w_c_next;
        end
        r_disp <= w_disp_next;
        r_ptr  <= w_ptr_next;
      end
      r_point <= pointEn ? (w_adv ? w_ptr_next : r_ptr) : '0;
      r_tick  <= w_adv;
    end
  end

  assign dispVal = r_disp;
  assign point   = r_point;
  assign tick    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_disp_pattern_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_disp_pattern_gen
// Description : Self-checking bench for disp_pattern_gen (NDIG=4,
//               PRESCALE=4). Directed scenarios followed by random stimulus,
//               all compared against an advance-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_pattern_gen;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 4;

  logic              clk5 = 1'b0;
  logic              reset;
  logic [1:0]        mode;
  logic              run;
  logic              step;
  logic              clr;
  logic              pointEn;
  logic [4*NDIG-1:0] dispVal;
  logic [NDIG-1:0]   point;
  logic              tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: everything derived from number of advances since re-init.
  int m_cnt  = 0;
  int m_adv  = 0;
  int m_ptr  = 0;
  int m_mode = 0;
  bit m_pe   = 1'b0;
  bit m_tick = 1'b0;

  disp_pattern_gen #(.NDIG(NDIG), .PRESCALE(PRESCALE)) u_dut (
    .clk5    (clk5),
    .reset   (reset),
    .mode    (mode),
    .run     (run),
    .step    (step),
    .clr     (clr),
    .pointEn (pointEn),
    .dispVal (dispVal),
    .point   (point),
    .tick    (tick)
  );

  // 5 MHz clock
  always #100 clk5 = ~clk5;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*NDIG-1:0] exp_disp(input int md, input int v);
    logic [4*NDIG-1:0] r;
    int c;
    r = '0;
    case (md)
      0: begin
        c = v % (1 << (NDIG + 3));
        for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'((c >> i) & 15);
      end
      1: begin
        c = v % 10000;
        for (int i = 0; i < NDIG; i++) begin
          r[4*i +: 4] = 4'(c % 10);
          c = c / 10;
        end
      end
      2: for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'((i - (v % NDIG) + NDIG) % NDIG);
      default: for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'(v % 16);
    endcase
    return r;
  endfunction

  task automatic model_edge();
    bit adv;
    if (reset || clr || (int'(mode) != m_mode)) begin
      m_cnt  = 0;
      m_adv  = 0;
      m_ptr  = 0;
      m_tick = 1'b0;
      m_mode = int'(mode);
    end else begin
      adv    = run ? (m_cnt == PRESCALE - 1) : step;
      m_cnt  = run ? (m_cnt + 1) % PRESCALE : 0;
      if (adv) begin
        m_adv++;
        m_ptr = (m_ptr + 1) % NDIG;
      end
      m_tick = adv;
    end
    m_pe = pointEn;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk5);
      model_edge();
      #1;
      check_val("model_disp",  32'(dispVal), 32'(exp_disp(m_mode, m_adv)));
      check_val("model_point", 32'(point),   m_pe ? (32'd1 << m_ptr) : 32'd0);
      check_val("model_tick",  32'(tick),    32'(m_tick));
    end
  endtask

  initial begin
    bit found;

    // Reset state, mode 0 free-running
    reset = 1'b1; mode = 2'd0; run = 1'b1; step = 1'b0; clr = 1'b0; pointEn = 1'b1;
    run_cycles(2);
    check_val("rst_disp",  32'(dispVal), 32'h0000);
    check_val("rst_point", 32'(point),   32'h1);
    check_val("rst_tick",  32'(tick),    32'h0);
    reset = 1'b0;
    run_cycles(4);
    check_val("m0_first_disp", 32'(dispVal), 32'h0001);
    check_val("m0_first_tick", 32'(tick),    32'h1);
    run_cycles(1);
    check_val("m0_tick_once",  32'(tick),    32'h0);
    run_cycles(59);
    check_val("m0_16adv_disp",  32'(dispVal), 32'h2480);
    check_val("m0_16adv_point", 32'(point),   32'h1);

    // BCD: 10 timed advances, then one step per cycle up to wrap
    mode = 2'd1;
    run_cycles(1);
    check_val("m1_init", 32'(dispVal), 32'h0000);
    run_cycles(40);
    check_val("m1_10adv", 32'(dispVal), 32'h0010);
    run = 1'b0; step = 1'b1;
    run_cycles(9989);
    check_val("m1_9999", 32'(dispVal), 32'h9999);
    run_cycles(1);
    check_val("m1_wrap", 32'(dispVal), 32'h0000);
    step = 1'b0;

    // Rotate and uniform from reset
    reset = 1'b1; mode = 2'd2;
    run_cycles(1);
    check_val("m2_init", 32'(dispVal), 32'h3210);
    reset = 1'b0; step = 1'b1;
    run_cycles(1);
    check_val("m2_1adv", 32'(dispVal), 32'h2103);
    run_cycles(3);
    check_val("m2_4adv", 32'(dispVal), 32'h3210);
    reset = 1'b1; mode = 2'd3;
    run_cycles(1);
    reset = 1'b0;
    run_cycles(17);
    check_val("m3_17adv", 32'(dispVal), 32'h1111);
    step = 1'b0;

    // Frozen, then three single steps
    run_cycles(100);
    check_val("frz_disp",  32'(dispVal), 32'h1111);
    check_val("frz_point", 32'(point),   32'h2);
    check_val("frz_tick",  32'(tick),    32'h0);
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      run_cycles(1);
      step = 1'b0;
      check_val("step_tick", 32'(tick), 32'h1);
      run_cycles(2);
      check_val("step_tick_low", 32'(tick), 32'h0);
    end
    check_val("step_disp", 32'(dispVal), 32'h4444);

    // Mode change coincident with a timed advance
    mode = 2'd0; run = 1'b1;
    run_cycles(6);
    found = 1'b0;
    for (int w = 0; w < 2 * PRESCALE && !found; w++) begin
      if (m_cnt == PRESCALE - 1) found = 1'b1;
      else run_cycles(1);
    end
    check_val("mchg_sync", 32'(found), 32'h1);
    mode = 2'd2;
    run_cycles(1);
    check_val("mchg_disp",  32'(dispVal), 32'h3210);
    check_val("mchg_point", 32'(point),   32'h1);
    check_val("mchg_tick",  32'(tick),    32'h0);
    run_cycles(3);
    check_val("mchg_cnt0_hold", 32'(dispVal), 32'h3210);
    run_cycles(1);
    check_val("mchg_cnt0_adv", 32'(dispVal), 32'h2103);

    // clr wins over a simultaneous step
    run = 1'b0; step = 1'b1;
    run_cycles(2);
    clr = 1'b1;
    run_cycles(1);
    clr = 1'b0; step = 1'b0;
    check_val("clr_disp", 32'(dispVal), 32'h3210);
    check_val("clr_tick", 32'(tick),    32'h0);

    // Random stimulus against the model
    for (int r = 0; r < 3000; r++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) run = ~run;
      step = ($urandom_range(0, 3) == 0);
      clr  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 15) == 0) pointEn = ~pointEn;
      run_cycles(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
